// File: rtl/div_ctrl_pkg.sv
// Shared definitions for the divide controller: FSM encoding, result-field
// layout and default operand width.
package div_ctrl_pkg;

  localparam int DATA_W_DEF = 32;

  // result word is {remainder, quotient}: field index times DATA_W gives the LSB
  localparam int QUO_FIELD = 0;
  localparam int REM_FIELD = 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } div_state_e;

endpackage

// File: rtl/div_ctrl_if.sv
// Pipeline/divider-facing bundle of the divide controller; the slave modport
// is the controller's view, the master modport the surrounding logic's.
interface div_ctrl_if
  import div_ctrl_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
);

  logic                  req_i;
  logic                  signed_i;
  logic [DATA_W-1:0]     op1_i;
  logic [DATA_W-1:0]     op2_i;
  logic                  flush_i;
  logic                  pipe_pause_i;
  logic                  pause_req_o;
  logic [2*DATA_W-1:0]   result_o;
  logic                  result_valid_o;
  logic                  div_start_o;
  logic                  div_cancel_o;
  logic                  div_signed_o;
  logic [DATA_W-1:0]     div_op1_o;
  logic [DATA_W-1:0]     div_op2_o;
  logic [2*DATA_W-1:0]   div_result_i;
  logic                  div_done_i;

  modport slave (
    input  req_i, signed_i, op1_i, op2_i, flush_i, pipe_pause_i,
           div_result_i, div_done_i,
    output pause_req_o, result_o, result_valid_o, div_start_o,
           div_cancel_o, div_signed_o, div_op1_o, div_op2_o
  );

  modport master (
    output req_i, signed_i, op1_i, op2_i, flush_i, pipe_pause_i,
           div_result_i, div_done_i,
    input  pause_req_o, result_o, result_valid_o, div_start_o,
           div_cancel_o, div_signed_o, div_op1_o, div_op2_o
  );

endinterface

// File: rtl/div_result_cache.sv
// Single-entry memo of the last divider result, keyed by {op1, op2, signed}.
// Only instantiated when DIV_RESULT_REUSE_EN is defined.
module div_result_cache
  import div_ctrl_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                wr_en,
  input  logic [DATA_W-1:0]   wr_op1,
  input  logic [DATA_W-1:0]   wr_op2,
  input  logic                wr_signed,
  input  logic [2*DATA_W-1:0] wr_result,
  input  logic [DATA_W-1:0]   lk_op1,
  input  logic [DATA_W-1:0]   lk_op2,
  input  logic                lk_signed,
  output logic                hit,
  output logic [2*DATA_W-1:0] hit_result
);

  logic [DATA_W-1:0]   op1_r;
  logic [DATA_W-1:0]   op2_r;
  logic                signed_r;
  logic [2*DATA_W-1:0] result_r;
  logic                valid_r;

  // Entry storage, overwritten on every divider completion
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op1_r    <= {DATA_W{1'b0}};
      op2_r    <= {DATA_W{1'b0}};
      signed_r <= 1'b0;
      result_r <= {(2*DATA_W){1'b0}};
      valid_r  <= 1'b0;
    end else if (wr_en) begin
      op1_r    <= wr_op1;
      op2_r    <= wr_op2;
      signed_r <= wr_signed;
      result_r <= wr_result;
      valid_r  <= 1'b1;
    end else begin
      valid_r  <= valid_r;
    end
  end

  assign hit = valid_r && (op1_r == lk_op1) && (op2_r == lk_op2) && (signed_r == lk_signed);
  assign hit_result = result_r;

endmodule

// File: rtl/div_ctrl.sv
// EX-stage divide controller: sequences an external divider, short-cuts
// divide-by-zero, and (with DIV_RESULT_REUSE_EN) reuses the last result.
module div_ctrl
  import div_ctrl_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
) (
  input logic       clk,
  input logic       rst,
  div_ctrl_if.slave bus
);

  localparam int RES_W = 2 * DATA_W;

  div_state_e         state_r;
  logic [DATA_W-1:0]  op1_r;
  logic [DATA_W-1:0]  op2_r;
  logic               signed_r;
  logic [RES_W-1:0]   result_r;

  logic               div_zero_s;
  logic               hit_s;
  logic               cache_wr_s;
  logic [RES_W-1:0]   hit_result_s;
  logic [RES_W-1:0]   zero_result_s;

  assign div_zero_s = (bus.op2_i == {DATA_W{1'b0}});
  assign cache_wr_s = (state_r == ST_BUSY) && bus.div_done_i && !bus.flush_i;

  // Divide-by-zero answer: all-ones quotient, dividend as remainder
  always_comb begin
    zero_result_s = {RES_W{1'b0}};
    zero_result_s[QUO_FIELD*DATA_W +: DATA_W] = {DATA_W{1'b1}};
    zero_result_s[REM_FIELD*DATA_W +: DATA_W] = bus.op1_i;
  end

`ifdef DIV_RESULT_REUSE_EN
  div_result_cache #(.DATA_W(DATA_W)) u_cache (
    .clk        (clk),
    .rst        (rst),
    .wr_en      (cache_wr_s),
    .wr_op1     (op1_r),
    .wr_op2     (op2_r),
    .wr_signed  (signed_r),
    .wr_result  (bus.div_result_i),
    .lk_op1     (bus.op1_i),
    .lk_op2     (bus.op2_i),
    .lk_signed  (bus.signed_i),
    .hit        (hit_s),
    .hit_result (hit_result_s)
  );
`else
  assign hit_s        = 1'b0;
  assign hit_result_s = {RES_W{1'b0}};
`endif

  // Control FSM with operand and result registers; flush beats everything
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r  <= ST_IDLE;
      op1_r    <= {DATA_W{1'b0}};
      op2_r    <= {DATA_W{1'b0}};
      signed_r <= 1'b0;
      result_r <= {RES_W{1'b0}};
    end else if (bus.flush_i) begin
      state_r  <= ST_IDLE;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (bus.req_i) begin
            op1_r    <= bus.op1_i;
            op2_r    <= bus.op2_i;
            signed_r <= bus.signed_i;
            if (div_zero_s) begin
              state_r  <= ST_DONE;
              result_r <= zero_result_s;
            end else if (hit_s) begin
              state_r  <= ST_DONE;
              result_r <= hit_result_s;
            end else begin
              state_r  <= ST_BUSY;
            end
          end else begin
            state_r <= ST_IDLE;
          end
        end
        ST_BUSY: begin
          if (bus.div_done_i) begin
            result_r <= bus.div_result_i;
            state_r  <= ST_DONE;
          end else begin
            state_r  <= ST_BUSY;
          end
        end
        ST_DONE: begin
          if (!bus.pipe_pause_i) begin
            state_r <= ST_IDLE;
          end else begin
            state_r <= ST_DONE;
          end
        end
        default: state_r <= ST_IDLE;
      endcase
    end
  end

  // Stall and start/cancel must react to req/flush in the same cycle
  assign bus.pause_req_o    = !rst && (((state_r == ST_IDLE) && bus.req_i) || (state_r == ST_BUSY));
  assign bus.div_start_o    = (state_r == ST_BUSY) && !bus.flush_i;
  assign bus.div_cancel_o   = (state_r == ST_BUSY) && bus.flush_i;
  assign bus.result_valid_o = (state_r == ST_DONE);
  assign bus.result_o       = result_r;
  assign bus.div_signed_o   = signed_r;
  assign bus.div_op1_o      = op1_r;
  assign bus.div_op2_o      = op2_r;

endmodule
